// File: rtl/liang_pkg.sv
// Shared types and constants for the liang core front end.
package liang_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] inst_t;
    typedef logic [7:0]  cnt_t;

    localparam pc_t RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_RESP,
        S_OUT,
        S_NPC
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: request, wait (with timeout), present to
// decode, then wait for the backend to supply the next PC.
module inst_fetch
    import liang_pkg::*;
#(
    parameter pc_t         RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    input  logic        imem_resp_err_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        fetch_err_o,
    input  logic        npc_valid_i,
    input  logic [31:0] npc_i
);

    localparam cnt_t TMO = cnt_t'(TIMEOUT);

    fetch_state_e state_q, state_d;
    pc_t          pc_q, pc_d;
    inst_t        inst_q, inst_d;
    logic         err_q, err_d;
    cnt_t         cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_REQ: begin
                if (imem_req_ready_i) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end
            end
            S_RESP: begin
                // A response in the timeout cycle still wins; the counter never
                // passes TMO because the state is left when it gets there.
                if (imem_resp_valid_i) begin
                    inst_d  = imem_resp_data_i;
                    err_d   = imem_resp_err_i;
                    state_d = S_OUT;
                end else if (cnt_q == TMO) begin
                    inst_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (inst_ready_i) begin
                    state_d = S_NPC;
                end
            end
            S_NPC: begin
                if (npc_valid_i) begin
                    pc_d = npc_i;
                    // Misaligned targets fault locally without touching memory.
                    if (npc_i[1:0] != 2'b00) begin
                        inst_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign imem_req_valid_o = (state_q == S_REQ) && !rst_i;
    assign imem_req_addr_o  = pc_q;
    assign inst_valid_o     = (state_q == S_OUT);
    assign inst_o           = inst_q;
    assign pc_o             = pc_q;
    assign fetch_err_o      = err_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of response-wait cycles before a fetch error (range 1..255).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req_valid_o, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_ready_i, input, 1 bit: memory accepts the request.
REQ-007 SHALL have port imem_req_addr_o, output, 32 bits: fetch address, always equal to pc_o.
REQ-008 SHALL have port imem_resp_valid_i, input, 1 bit: response data valid.
REQ-009 SHALL have port imem_resp_data_i, input, 32 bits: instruction word.
REQ-010 SHALL have port imem_resp_err_i, input, 1 bit: access fault, qualified by imem_resp_valid_i.
REQ-011 SHALL have port inst_valid_o, output, 1 bit: instruction available to decode.
REQ-012 SHALL have port inst_ready_i, input, 1 bit: decode accepts the instruction.
REQ-013 SHALL have port inst_o, output, 32 bits: fetched instruction.
REQ-014 SHALL have port pc_o, output, 32 bits: PC of the current fetch or of the presented instruction.
REQ-015 SHALL have port fetch_err_o, output, 1 bit: the presented instruction carries a fetch fault; valid with inst_valid_o.
REQ-016 SHALL have port npc_valid_i, input, 1 bit: the backend supplies the next PC.
REQ-017 SHALL have port npc_i, 32 bits, input: the next PC (sequential or branch target, already resolved).

Function
REQ-018 SHALL implement the FSM states S_REQ, S_RESP, S_OUT and S_NPC.
REQ-019 In S_REQ, imem_req_valid_o SHALL be 1; when imem_req_ready_i=1, the FSM SHALL move to S_RESP and clear the timeout counter to 0.
REQ-020 In S_RESP, the counter SHALL increment each cycle without imem_resp_valid_i, and SHALL saturate at TIMEOUT; it SHALL NOT wrap.
REQ-021 In S_RESP, when imem_resp_valid_i=1, the block SHALL register the following and move to S_OUT:
- inst_o = imem_resp_data_i
- fetch_err_o = imem_resp_err_i
REQ-022 In S_RESP, when the counter equals TIMEOUT and imem_resp_valid_i=0, the block SHALL set fetch_err_o=1 and inst_o=0, and move to S_OUT.
REQ-023 If a response arrives in the same cycle the counter reaches TIMEOUT, the response SHALL win.
REQ-024 In S_OUT, inst_valid_o SHALL be 1, and inst_o, pc_o and fetch_err_o SHALL be held stable until inst_ready_i=1; the FSM SHALL then move to S_NPC.
REQ-025 inst_valid_o SHALL be 1 only in S_OUT, and imem_req_valid_o SHALL be 1 only in S_REQ.
REQ-026 In S_NPC, when npc_valid_i=1, the block SHALL load pc from npc_i and move to S_REQ; the first request SHALL appear the following cycle.
REQ-027 npc_valid_i outside S_NPC, and imem_resp_valid_i outside S_RESP, SHALL be ignored with no state change.
REQ-028 If npc_i[1:0] != 0, the block SHALL load pc and then go directly to S_OUT with fetch_err_o=1 and inst_o=0, with no memory request issued.
REQ-029 Minimum latency, with memory responding the cycle after acceptance and decode always ready, SHALL be 4 cycles per instruction, counted from S_NPC accept to the next S_NPC entry.
REQ-030 The response SHALL arrive no earlier than the cycle after request acceptance; a response in the acceptance cycle SHALL be ignored.

Reset
REQ-031 On rst_i=1, asynchronously and regardless of state, the block SHALL force:
- state = S_REQ
- pc = RESET_PC
- inst_o = 0
- fetch_err_o = 0
- counter = 0
- inst_valid_o = 0
REQ-032 While rst_i=1, imem_req_valid_o SHALL be 0, and imem_req_addr_o and pc_o SHALL read RESET_PC.
REQ-033 On the first clock edge after deassertion, imem_req_valid_o SHALL be 1; any fetch in flight at reset SHALL be abandoned.

Structure
REQ-034 The FSM state enum fetch_state_e and a RESET_PC_DEFAULT constant SHALL live in liang_pkg; the PC SHALL use the existing pc_t and the instruction the existing inst_t.
REQ-035 The block SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-036 Release reset; memory ready at once and responds 32'h00100093 one cycle later; decode ready -> the bench SHALL see:
- imem_req_addr_o = 80000000
- inst_o = 00100093 and pc_o = 80000000 with inst_valid_o=1
- fetch_err_o = 0
REQ-037 Hold inst_ready_i=0 for 5 cycles in S_OUT -> inst_valid_o, inst_o and pc_o SHALL stay constant for all 5 cycles; S_NPC is entered the cycle after ready.
REQ-038 npc_i = 80000010 with npc_valid_i=1 -> the next request SHALL carry address 80000010; a spurious npc_valid_i during S_RESP SHALL have no effect.
REQ-039 With TIMEOUT=4 and no response -> fetch_err_o=1 and inst_o=0; the response in the same cycle as the counter reaching 4 SHALL return normal data.
REQ-040 npc_i = 80000002 -> no imem_req_valid_o pulse, and inst_valid_o=1 with fetch_err_o=1.
REQ-041 Assert rst_i mid-S_RESP -> the late response SHALL be ignored, and the next request SHALL carry address 80000000.
